uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//  Serial transmit stage sitting directly downstream of the TX fifo read port.
//  Pops one word per frame from the fifo, honours its 1-cycle synchronous read latency,
//  and serialises the low DATA_BITS bits LSB-first as an async frame:
//  start, data, optional parity, 1 or 2 stop bits. Config comes from APB registers upstream.
// PARAMETERS
//  DWIDTH     32  fifo word width; bits [DWIDTH-1:DATA_BITS] are ignored
//  DATA_BITS   8  data bits per frame (5..9, must be <= DWIDTH)
// PORTS
//  CLK         in   1          clock
//  RST         in   1          async reset, active-low
//  EN          in   1          transmitter enable; gates start of new frames only
//  BAUD_DIV    in   16         CLK cycles per bit minus 1 (0 => 1 cycle/bit)
//  PARITY_EN   in   1          1 = insert parity bit after data
//  PARITY_ODD  in   1          1 = odd parity, 0 = even
//  STOP2       in   1          1 = two stop bits, 0 = one
//  FIFO_EMPTY  in   1          fifo EMPTY flag
//  FIFO_RD_EN  out  1          fifo read strobe, exactly one cycle per frame
//  FIFO_DOUT   in   DWIDTH     fifo read data, valid the cycle after the RD_EN cycle
//  TXD         out  1          serial line, idle high, registered
//  BUSY        out  1          1 in any state other than IDLE
//  FRAME_DONE  out  1          1-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  Reset (async, RST=0): state IDLE, TXD=1, FIFO_RD_EN=0, BUSY=0, FRAME_DONE=0,
//   counters/shift reg cleared; any in-flight frame is abandoned and its popped word lost.
//  FSM: IDLE -> POP -> LATCH -> START -> DATA -> [PARITY] -> STOP -> IDLE/POP.
//  IDLE : TXD=1. EN=1 & FIFO_EMPTY=0 -> POP on next edge.
//  POP  : FIFO_RD_EN=1 for this single cycle; always -> LATCH.
//  LATCH: capture FIFO_DOUT[DATA_BITS-1:0] into shift reg; snapshot BAUD_DIV,
//         PARITY_EN, PARITY_ODD, STOP2; compute parity = ^data ^ PARITY_ODD -> START.
//  START: TXD=0 for BAUD_DIV+1 cycles.
//  DATA : DATA_BITS bits, LSB first, each BAUD_DIV+1 cycles; bit counter 0..DATA_BITS-1.
//  PARITY (only if snapshot PARITY_EN): TXD=parity for BAUD_DIV+1 cycles.
//  STOP : TXD=1 for (STOP2?2:1)*(BAUD_DIV+1) cycles; FRAME_DONE pulses in the last one.
//  After STOP: EN=1 & FIFO_EMPTY=0 -> POP directly (2 idle-high cycles between frames
//   from POP+LATCH); else IDLE.
//  TXD is registered: value for a state appears on TXD at the cycle that state is entered.
//  Baud counter is 16-bit, counts 0..BAUD_DIV then reloads; no wrap beyond snapshot value.
//  Config inputs are don't-care outside LATCH; mid-frame changes affect the next frame only.
//  EN falling mid-frame: current frame completes in full; no further POP.
//  FIFO_EMPTY rising during START..STOP: no effect on current frame.
//  FIFO_RD_EN never asserted while FIFO_EMPTY=1 at the decision edge; never 2 cycles in a row.
//  Frame length (cycles, POP to end of STOP) = 2 + (BAUD_DIV+1)*(1+DATA_BITS+PE+1+STOP2).
// TESTING
//  1 Reset: RST=0 mid-DATA -> TXD=1, BUSY=0, FIFO_RD_EN=0 same cycle; no FRAME_DONE.
//  2 Fifo holds 0x000000A5, BAUD_DIV=3, PE=0, STOP2=0, EN=1 -> one RD_EN pulse; TXD bits
//    0,1,0,1,0,0,1,0,1,1 each 4 cycles; FRAME_DONE after 42 cycles from POP; IDLE after.
//  3 Data 0x07, PE=1, PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> 0; STOP2=1 -> 2 stop bits.
//  4 Fifo holds 3 words, BAUD_DIV=0 -> 3 back-to-back frames, exactly 2 TXD-high cycles
//    between stop and next start; 3 RD_EN pulses; FIFO_EMPTY ends 1, BUSY falls.
//  5 EN dropped during DATA of frame 1 with 2 words queued -> frame 1 completes, no 2nd POP;
//    EN raised again -> frame 2 starts from IDLE.
//  6 BAUD_DIV changed 3->7 mid-frame -> current frame keeps 4 cycles/bit, next uses 8.

Source files
------------

// File: rtl/uart_tx_drain.sv
// Async-frame transmitter that pops one word per frame from a 1-cycle-latency fifo
// and shifts its low DATA_BITS bits out LSB-first with optional parity and 1/2 stop bits.
module uart_tx_drain #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [15:0]       BAUD_DIV,
   input  logic              PARITY_EN,
   input  logic              PARITY_ODD,
   input  logic              STOP2,
   input  logic              FIFO_EMPTY,
   output logic              FIFO_RD_EN,
   input  logic [DWIDTH-1:0] FIFO_DOUT,
   output logic              TXD,
   output logic              BUSY,
   output logic              FRAME_DONE
);

   localparam int unsigned    BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LATCH,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            baud_cnt_q, baud_cnt_d;
   logic [15:0]            div_q, div_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   pe_q, pe_d;
   logic                   par_q, par_d;
   logic                   stop2_q, stop2_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   txd_q, txd_d;
   logic                   rd_en_q, rd_en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   tick;
   logic                   want_frame;

   if (DWIDTH > DATA_BITS) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^FIFO_DOUT[DWIDTH-1:DATA_BITS];
   end

   assign tick       = (baud_cnt_q == div_q);
   assign want_frame = EN && !FIFO_EMPTY;

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pe_d       = pe_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (want_frame) state_d = S_POP;
         end
         S_POP: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            shift_d    = FIFO_DOUT[DATA_BITS-1:0];
            div_d      = BAUD_DIV;
            pe_d       = PARITY_EN;
            stop2_d    = STOP2;
            par_d      = (^FIFO_DOUT[DATA_BITS-1:0]) ^ PARITY_ODD;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = S_START;
         end
         S_START: begin
            if (tick) begin
               baud_cnt_d = '0;
               state_d    = S_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (tick) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = pe_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         S_PARITY: begin
            if (tick) begin
               baud_cnt_d = '0;
               state_d    = S_STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (tick) begin
               baud_cnt_d = '0;
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = want_frame ? S_POP : S_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are derived from the next state so they are registered yet line up with it.
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase
      rd_en_d = (state_d == S_POP);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_STOP) && (baud_cnt_d == div_d) && (stop_cnt_d == stop2_d);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         pe_q       <= 1'b0;
         par_q      <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         pe_q       <= pe_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TXD        = txd_q;
   assign FIFO_RD_EN = rd_en_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a fifo model feeds the DUT and a frame-level model predicts
// TXD/RD_EN/BUSY/FRAME_DONE every cycle; directed frames pin the model with literals.
module tb_uart_tx_drain;

   localparam int unsigned DWIDTH    = 32;
   localparam int unsigned DATA_BITS = 8;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              EN = 1'b0;
   logic [15:0]       BAUD_DIV = '0;
   logic              PARITY_EN = 1'b0;
   logic              PARITY_ODD = 1'b0;
   logic              STOP2 = 1'b0;
   logic              FIFO_EMPTY;
   logic              FIFO_RD_EN;
   logic [DWIDTH-1:0] FIFO_DOUT = '0;
   logic              TXD;
   logic              BUSY;
   logic              FRAME_DONE;

   uart_tx_drain #(.DWIDTH(DWIDTH), .DATA_BITS(DATA_BITS)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (EN),
      .BAUD_DIV   (BAUD_DIV),
      .PARITY_EN  (PARITY_EN),
      .PARITY_ODD (PARITY_ODD),
      .STOP2      (STOP2),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_RD_EN (FIFO_RD_EN),
      .FIFO_DOUT  (FIFO_DOUT),
      .TXD        (TXD),
      .BUSY       (BUSY),
      .FRAME_DONE (FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   // Fifo: storage written by the stimulus, read port with 1-cycle latency.
   logic [31:0] mem [0:1023];
   int unsigned wr_cnt = 0;
   int unsigned rd_cnt = 0;
   assign FIFO_EMPTY = (wr_cnt == rd_cnt);

   always @(posedge CLK) begin
      if (FIFO_RD_EN === 1'b1) begin
         FIFO_DOUT <= mem[rd_cnt % 1024];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   typedef struct packed {
      logic txd;
      logic rd;
      logic busy;
      logic done;
      logic pop;
      logic latch;
   } ent_t;

   localparam ent_t IDLE_E  = '{txd: 1'b1, rd: 1'b0, busy: 1'b0, done: 1'b0, pop: 1'b0, latch: 1'b0};
   localparam ent_t POP_E   = '{txd: 1'b1, rd: 1'b1, busy: 1'b1, done: 1'b0, pop: 1'b1, latch: 1'b0};
   localparam ent_t LATCH_E = '{txd: 1'b1, rd: 1'b0, busy: 1'b1, done: 1'b0, pop: 1'b0, latch: 1'b1};

   ent_t        exp_q [$];
   int unsigned mrd = 0;
   logic [31:0] cur_word = '0;
   int unsigned nchk = 0;
   int unsigned npass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act === req) npass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, req, $time);
   endtask

   // Expected waveform of a whole frame body, built from the config seen at LATCH.
   task automatic build_body(input logic [31:0] w);
      logic              bq [$];
      logic [DATA_BITS-1:0] d;
      int unsigned       per;
      ent_t              e;
      d   = w[DATA_BITS-1:0];
      per = int'(BAUD_DIV) + 1;
      bq.push_back(1'b0);
      for (int i = 0; i < int'(DATA_BITS); i++) bq.push_back(d[i]);
      if (PARITY_EN) bq.push_back((^d) ^ PARITY_ODD);
      bq.push_back(1'b1);
      if (STOP2) bq.push_back(1'b1);
      for (int b = 0; b < bq.size(); b++) begin
         for (int unsigned j = 0; j < per; j++) begin
            e       = IDLE_E;
            e.txd   = bq[b];
            e.busy  = 1'b1;
            e.done  = (b == bq.size() - 1) && (j == per - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic compare_loop();
      ent_t e;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            exp_q.delete();
            e = IDLE_E;
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
         end else begin
            e = IDLE_E;
         end
         chk("txd",        {31'b0, TXD},        {31'b0, e.txd});
         chk("rd_en",      {31'b0, FIFO_RD_EN}, {31'b0, e.rd});
         chk("busy",       {31'b0, BUSY},       {31'b0, e.busy});
         chk("frame_done", {31'b0, FRAME_DONE}, {31'b0, e.done});
         if (RST) begin
            if (e.pop) begin
               cur_word = mem[mrd % 1024];
               mrd++;
            end
            if (e.latch) build_body(cur_word);
            if (exp_q.size() == 0 && EN && wr_cnt != mrd) begin
               exp_q.push_back(POP_E);
               exp_q.push_back(LATCH_E);
            end
         end
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_cnt % 1024] = w;
      wr_cnt++;
   endtask

   task automatic wait_rd();
      int unsigned t = 0;
      @(negedge CLK);
      while (FIFO_RD_EN !== 1'b1 && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      chk("pop_seen", {31'b0, FIFO_RD_EN}, 32'd1);
   endtask

   task automatic wait_done();
      int unsigned t = 0;
      while (FRAME_DONE !== 1'b1 && t < 5000) begin
         @(negedge CLK);
         t++;
      end
      chk("done_seen", {31'b0, FRAME_DONE}, 32'd1);
   endtask

   // Samples the first cycle of each bit; len counts POP as cycle 1 up to FRAME_DONE.
   task automatic capture(input int unsigned div, input int unsigned nbits,
                          output logic [15:0] bits, output int unsigned len);
      bits = '0;
      wait_rd();
      len = 1;
      while (FRAME_DONE !== 1'b1 && len < 5000) begin
         @(negedge CLK);
         len++;
         if (len >= 3 && (len - 3) % (div + 1) == 0 && (len - 3) / (div + 1) < nbits)
            bits[(len - 3) / (div + 1)] = TXD;
      end
      chk("done_seen", {31'b0, FRAME_DONE}, 32'd1);
   endtask

   initial begin
      logic [15:0] bits;
      int unsigned len, len2, nrd, ndone, to;

      fork
         compare_loop();
      join_none

      // Reset values
      cyc(3);
      chk("rst_txd",  {31'b0, TXD},        32'd1);
      chk("rst_busy", {31'b0, BUSY},       32'd0);
      chk("rst_rd",   {31'b0, FIFO_RD_EN}, 32'd0);
      chk("rst_done", {31'b0, FRAME_DONE}, 32'd0);
      RST = 1'b1;
      cyc(2);

      // Single 0xA5 frame, 4 cycles per bit
      BAUD_DIV = 16'd3; PARITY_EN = 1'b0; PARITY_ODD = 1'b0; STOP2 = 1'b0; EN = 1'b1;
      push(32'h0000_00A5);
      capture(3, 10, bits, len);
      chk("a5_len",  len, 32'd42);
      chk("a5_bits", {22'b0, bits[9:0]}, 32'h34A);
      cyc(3);

      // Parity even + two stop bits, then odd parity
      BAUD_DIV = 16'd1; PARITY_EN = 1'b1; PARITY_ODD = 1'b0; STOP2 = 1'b1;
      push(32'hFFFF_FF07);
      capture(1, 12, bits, len);
      chk("even_len",   len, 32'd26);
      chk("even_par",   {31'b0, bits[9]},  32'd1);
      chk("even_stop2", {30'b0, bits[11:10]}, 32'd3);
      cyc(2);
      PARITY_ODD = 1'b1; STOP2 = 1'b0;
      push(32'h0000_0007);
      capture(1, 11, bits, len);
      chk("odd_len", len, 32'd24);
      chk("odd_par", {31'b0, bits[9]}, 32'd0);
      cyc(2);

      // Three back-to-back frames at 1 cycle per bit
      BAUD_DIV = 16'd0; PARITY_EN = 1'b0; STOP2 = 1'b0;
      push($urandom); push($urandom); push($urandom);
      wait_rd();
      len = 1; nrd = 1; ndone = 0;
      while (ndone < 3 && len < 5000) begin
         @(negedge CLK);
         len++;
         if (FIFO_RD_EN === 1'b1) nrd++;
         if (FRAME_DONE === 1'b1) ndone++;
      end
      chk("b2b_len",  len, 32'd36);
      chk("b2b_pops", nrd, 32'd3);
      @(negedge CLK);
      chk("b2b_busy",  {31'b0, BUSY},       32'd0);
      chk("b2b_empty", {31'b0, FIFO_EMPTY}, 32'd1);
      cyc(2);

      // EN dropped mid-frame with a second word queued
      BAUD_DIV = 16'd3;
      push(32'h0000_0011); push(32'h0000_0022);
      wait_rd();
      cyc(8);
      EN = 1'b0;
      wait_done();
      nrd = 0;
      repeat (12) begin
         @(negedge CLK);
         if (FIFO_RD_EN === 1'b1) nrd++;
      end
      chk("en_off_pops", nrd, 32'd0);
      chk("en_off_busy", {31'b0, BUSY}, 32'd0);
      cyc(1);
      EN = 1'b1;
      capture(3, 10, bits, len);
      chk("en_on_len", len, 32'd42);
      cyc(2);

      // BAUD_DIV change mid-frame applies to the next frame only
      BAUD_DIV = 16'd3;
      push(32'h0000_00A5); push(32'h0000_005A);
      fork
         capture(3, 10, bits, len);
         begin
            cyc(15);
            BAUD_DIV = 16'd7;
         end
      join
      chk("div_f1_len", len, 32'd42);
      capture(7, 10, bits, len2);
      chk("div_f2_len",  len2, 32'd82);
      chk("div_f2_bits", {22'b0, bits[9:0]}, 32'h2B4);
      cyc(3);

      // Reset asserted mid-DATA
      BAUD_DIV = 16'd3;
      push(32'h0000_00C3);
      wait_rd();
      cyc(10);
      RST = 1'b0;
      #1;
      chk("midrst_txd",  {31'b0, TXD},        32'd1);
      chk("midrst_busy", {31'b0, BUSY},       32'd0);
      chk("midrst_rd",   {31'b0, FIFO_RD_EN}, 32'd0);
      chk("midrst_done", {31'b0, FRAME_DONE}, 32'd0);
      EN = 1'b0;
      cyc(3);
      RST = 1'b1;
      cyc(6);

      // Randomised traffic and configuration
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK);
         #1;
         BAUD_DIV   = 16'($urandom_range(0, 3));
         PARITY_EN  = 1'($urandom_range(0, 1));
         PARITY_ODD = 1'($urandom_range(0, 1));
         STOP2      = 1'($urandom_range(0, 1));
         EN         = ($urandom_range(0, 99) < 90);
         if ($urandom_range(0, 47) == 0 && wr_cnt < 900) push($urandom);
      end

      // Drain
      EN = 1'b1;
      to = 0;
      while ((BUSY !== 1'b0 || FIFO_EMPTY !== 1'b1) && to < 20000) begin
         cyc(1);
         to++;
      end
      chk("drain_busy",  {31'b0, BUSY},       32'd0);
      chk("drain_empty", {31'b0, FIFO_EMPTY}, 32'd1);
      cyc(3);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
